// File: rtl/alu_seq.sv
// Sequential ALU for the CPU datapath.
// Operands are written into AC/BC, then each accepted start runs one op.
// Single-cycle ops pass IDLE -> EXEC -> DONE. MUL passes IDLE -> MUL -> DONE.
// MUL spends WIDTH shift-add steps plus one write-back cycle in the MUL state.
// The result and flags are held until the next op that writes them.
// The d/d_hi/fo bus is tri-stated combinationally on oe_i.
module alu_seq #(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wa_i,
    input  logic             wb_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    input  logic             start_i,
    input  logic             oe_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic [WIDTH-1:0] d_hi_o,
    output logic [7:0]       fo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     ac_q;
    logic [WIDTH-1:0]     bc_q;
    // Operand snapshot taken on an accepted start, so that a same-cycle
    // operand write only affects the following op.
    logic [WIDTH-1:0]     opa_q;
    logic [WIDTH-1:0]     opb_q;
    logic                 cin_q;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     res_q;
    logic [WIDTH-1:0]     hi_q;
    logic [3:0]           flg_q;        // {V,N,Z,C}
    logic [2*WIDTH-1:0]   prod_q;       // {partial high word, remaining multiplier bits}
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic                 done_q;

    // Arithmetic and shift results, one bit wider to carry C out.
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       dif_w;
    logic [WIDTH:0]       cmp_w;
    logic [WIDTH:0]       shl_w;
    logic [WIDTH:0]       shr_w;
    logic [WIDTH:0]       asr_w;
    logic [SHAMT_W-1:0]   shamt;

    logic [WIDTH-1:0]     alu_val;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_z;
    logic                 alu_n;
    logic                 alu_wr;
    logic                 alu_fl;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_d;

    assign shamt = opb_q[SHAMT_W-1:0];
    assign sum_w = {1'b0, opa_q} + {1'b0, opb_q} + {{WIDTH{1'b0}}, cin_q};
    assign dif_w = {1'b0, opa_q} - {1'b0, opb_q} - {{WIDTH{1'b0}}, cin_q};
    assign cmp_w = {1'b0, opa_q} - {1'b0, opb_q};
    // Left shift: the bit above the MSB is the last bit shifted out (0 for amount 0).
    assign shl_w = {1'b0, opa_q} << shamt;
    // Right shifts: the extra LSB is the last bit shifted out (0 for amount 0).
    assign shr_w = {opa_q, 1'b0} >> shamt;
    assign asr_w = $signed({opa_q, 1'b0}) >>> shamt;

    // One shift-add step: add the multiplicand into the high word when the
    // current multiplier bit is set, then shift the whole product right.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};

    // Single-cycle ALU: value, carry, overflow and which registers to update.
    always_comb begin
        alu_val = opa_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b0;
        alu_fl  = 1'b0;
        case (op_q)
            OP_ADD: begin
                {alu_c, alu_val} = sum_w;
                alu_v  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                         (sum_w[WIDTH-1] != opa_q[WIDTH-1]);
                alu_wr = 1'b1;
                alu_fl = 1'b1;
            end
            OP_SUB: begin
                {alu_c, alu_val} = dif_w;
                alu_v  = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                         (dif_w[WIDTH-1] != opa_q[WIDTH-1]);
                alu_wr = 1'b1;
                alu_fl = 1'b1;
            end
            OP_AND: begin
                alu_val = opa_q & opb_q;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OP_OR: begin
                alu_val = opa_q | opb_q;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OP_XOR: begin
                alu_val = opa_q ^ opb_q;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OP_NOT: begin
                alu_val = ~opa_q;
                alu_wr  = 1'b1;
                alu_fl  = 1'b1;
            end
            OP_SHL: begin
                {alu_c, alu_val} = shl_w;
                alu_wr = 1'b1;
                alu_fl = 1'b1;
            end
            OP_SHR: begin
                {alu_val, alu_c} = shr_w;
                alu_wr = 1'b1;
                alu_fl = 1'b1;
            end
            OP_ASR: begin
                {alu_val, alu_c} = asr_w;
                alu_wr = 1'b1;
                alu_fl = 1'b1;
            end
            OP_CMP: begin
                // CMP updates the flags only; the result register keeps its value.
                {alu_c, alu_val} = cmp_w;
                alu_v  = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                         (cmp_w[WIDTH-1] != opa_q[WIDTH-1]);
                alu_fl = 1'b1;
            end
            default: begin
                // NOP and the unused opcodes leave everything untouched.
                alu_val = opa_q;
                alu_wr  = 1'b0;
                alu_fl  = 1'b0;
            end
        endcase
        alu_z = (alu_val == {WIDTH{1'b0}});
        alu_n = alu_val[WIDTH-1];
    end

    // Operand registers: writable only while no op is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q <= {WIDTH{1'b0}};
            bc_q <= {WIDTH{1'b0}};
        end else if (!busy_q) begin
            if (wa_i) ac_q <= a_i;
            if (wb_i) bc_q <= b_i;
        end
    end

    // Control FSM with the result, flag and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            cin_q   <= 1'b0;
            op_q    <= OP_NOP;
            res_q   <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            flg_q   <= 4'b0000;
            prod_q  <= {(2*WIDTH){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        op_q   <= op_i;
                        opa_q  <= ac_q;
                        opb_q  <= bc_q;
                        cin_q  <= cin_i;
                        busy_q <= 1'b1;
                        if (op_i == OP_MUL) begin
                            prod_q  <= {{WIDTH{1'b0}}, bc_q};
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= ST_MUL;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (alu_wr) begin
                        res_q <= alu_val;
                        hi_q  <= {WIDTH{1'b0}};
                    end
                    if (alu_fl) begin
                        flg_q <= {alu_v, alu_n, alu_z, alu_c};
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_MUL: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        // All steps done: publish the product and its flags.
                        res_q   <= prod_q[WIDTH-1:0];
                        hi_q    <= prod_q[2*WIDTH-1:WIDTH];
                        flg_q   <= {1'b0,
                                    prod_q[WIDTH-1],
                                    (prod_q == {(2*WIDTH){1'b0}}),
                                    (prod_q[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}})};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign d_o    = oe_i ? res_q : {WIDTH{1'bz}};
    assign d_hi_o = oe_i ? hi_q  : {WIDTH{1'bz}};
    assign fo_o   = oe_i ? {4'b0000, flg_q} : 8'bzzzz_zzzz;

endmodule
